mmc3_scanline_irq: RTL and testbench
====================================

Name: mmc3_scanline_irq

Overview:
- Scanline IRQ stage sitting directly downstream of the cartridge top-level bus logic.
- Consumes the CPU write bus (romsel, cpu_rw_in, cpu_addr_in, cpu_data_in) and PPU address line A12.
- Drives the cartridge irq line consumed by the console.
- Filters PPU A12 rising edges in the m2 domain, clocks an MMC3-style reload/decrement counter, and asserts IRQ on zero when enabled.

Parameters:
- A12_LOW_MIN, 3, consecutive m2 cycles of synced A12 low required before a rise counts; range 1..7.
- MMC3_REV_A, 0, 1 = old-revision zero behaviour (see Behaviour); 0 = new revision.
- COUNTER_WIDTH, 8, width of the counter and the reload latch.

Ports:
- m2  input  1  CPU M2 clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- mapper_active  input  1  block selected by the current mapper configuration.
- romsel  input  1  active-low CPU $8000-$FFFF select.
- cpu_rw_in  input  1  1 = read, 0 = write.
- cpu_addr_in  input  15  CPU A14..A0.
- cpu_data_in  input  8  CPU data bus, sampled on a write.
- ppu_a12  input  1  raw PPU A12, asynchronous to m2.
- irq  output  1  active-low IRQ to the console.
- irq_pending  output  1  internal pending flag, for debug and bench.
- counter_value  output  COUNTER_WIDTH  current counter, for debug and bench.

Behaviour:
- Reset:
  - counter = 0, latch = 0, reload_flag = 0, irq_enable = 0, irq_pending = 0.
  - Both synchronizer flops = 0, prev_a12 = 0, low_cnt = 0.
  - irq = 1.
- Write strobe: wr = mapper_active & ~romsel & ~cpu_rw_in, sampled at the m2 rising edge; data is captured on the same edge.
- Register decode on wr, using cpu_addr_in[14:13] and [0]:
  - 2'b10, A0=0 ($C000): latch <= data.
  - 2'b10, A0=1 ($C001): counter <= 0, reload_flag <= 1.
  - 2'b11, A0=0 ($E000): irq_enable <= 0, irq_pending <= 0.
  - 2'b11, A0=1 ($E001): irq_enable <= 1.
  - All other addresses are ignored.
- A12 synchronizer: 2 flops; a12_s is the second-flop output; prev_a12 <= a12_s every cycle.
- low_cnt:
  - Increments while a12_s = 0, saturating at A12_LOW_MIN.
  - Clears to 0 on the cycle a12_s = 1.
- Clock event: a12_s = 1 & prev_a12 = 0 & low_cnt == A12_LOW_MIN (value before the clear).
  - Rises after shorter low pulses are discarded.
  - Latency: raw A12 rise to counter update = 3 m2 edges.
- On a clock event:
  - If counter == 0 or reload_flag = 1: counter <= latch, reload_flag <= 0.
  - Otherwise: counter <= counter - 1. No wrap is possible, since decrement only occurs from a nonzero value.
  - MMC3_REV_A = 0: irq_pending <= 1 if the new counter == 0 and irq_enable.
  - MMC3_REV_A = 1: irq_pending <= 1 only if the new counter == 0, irq_enable, and (old counter != 0 or reload_flag was 1).
- Simultaneous events in the same cycle:
  - A $C001 write beats a clock event; the event is dropped.
  - A $C000 write alongside an event: the reload uses the old latch.
  - A $E000 write beats any pending-set; irq_pending = 0.
  - A $E001 write alongside an event: the event sees irq_enable = 1.
- irq_pending stays set until a $E000 write or reset. Writes to $C000/$C001/$E001 do not clear it.
- irq = ~(irq_pending & mapper_active), registered, so it is 1 cycle behind irq_pending.
- mapper_active = 0:
  - Writes are ignored and irq = 1.
  - Counter, filter and latch state are held; clock events are still processed but cannot set irq_pending (irq_enable is untouched).
- Reset mid-operation: all state returns to reset values on the next edge; the first A12 rise after reset needs a full A12_LOW_MIN low window.

Test Plan:
- Reset, write $C000 = 3, $C001, $E001, then 5 filtered A12 rises (each with ≥3 low cycles) → counter 3,2,1,0,3; irq_pending set after the 4th rise; irq = 0 one cycle later.
- Latch = 2, enabled, A12 pulses with only 2 low cycles between rises → counter unchanged, irq stays 1; then a 3-low-cycle rise → counter reloads to 2.
- Pending set, write $E000 → irq_pending = 0, irq = 1 next cycle; further zero crossings give no IRQ until $E001.
- Latch = 0, enabled, repeated rises:
  - MMC3_REV_A = 0 → pending on every rise.
  - MMC3_REV_A = 1 → pending only on the rise after $C001, then none.
- $C001 write in the same cycle as a clock event with counter = 5 → counter = 0, reload_flag = 1; the next rise loads latch with no decrement.
- mapper_active = 0 with the counter reaching 0 and enabled → irq = 1 and writes ignored; assert reset mid-countdown → counter_value = 0, irq = 1 on the next edge.

Source files
------------

// File: rtl/mmc3_scanline_irq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmc3_scanline_irq_if
//  Purpose  : CPU write bus, PPU A12 and IRQ/debug signals for the MMC3
//             scanline IRQ stage, bundled as one interface.
//  Revision : 1.0  initial release
// ============================================================================
interface mmc3_scanline_irq_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     mapper_active;
  logic                     romsel;
  logic                     cpu_rw_in;
  logic [14:0]              cpu_addr_in;
  logic [7:0]               cpu_data_in;
  logic                     ppu_a12;
  logic                     irq;
  logic                     irq_pending;
  logic [COUNTER_WIDTH-1:0] counter_value;

  // Bus owner side (cartridge top level or bench)
  modport master (
    output mapper_active, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    input  irq, irq_pending, counter_value
  );

  // IRQ block side
  modport slave (
    input  mapper_active, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    output irq, irq_pending, counter_value
  );
endinterface
`default_nettype wire

// File: rtl/mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
//  Module   : mmc3_scanline_irq
//  Purpose  : MMC3-style scanline IRQ. Filters PPU A12 rising edges in the
//             M2 domain, clocks a reload/decrement counter and raises an
//             active-low IRQ when the counter reaches zero while enabled.
//  Revision : 1.0  initial release
// ============================================================================
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN   = 3,
  parameter bit MMC3_REV_A    = 1'b0,
  parameter int COUNTER_WIDTH = 8
) (
  input  wire logic          m2,
  input  wire logic          reset,
  mmc3_scanline_irq_if.slave bus
);

  localparam int                LOW_W     = 3;
  localparam logic [LOW_W-1:0]  c_low_min = LOW_W'(A12_LOW_MIN);
  localparam logic [1:0]        c_sel_c   = 2'b10;
  localparam logic [1:0]        c_sel_e   = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                     a12_meta_q;
  logic                     a12_s_q;
  logic                     prev_a12_q;
  logic [LOW_W-1:0]         low_cnt_q,  low_cnt_d;
  logic [COUNTER_WIDTH-1:0] counter_q,  counter_d;
  logic [COUNTER_WIDTH-1:0] latch_q,    latch_d;
  logic                     reload_q,   reload_d;
  logic                     irq_en_q,   irq_en_d;
  logic                     pending_q,  pending_d;
  logic                     irq_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                     w_wr;
  logic                     w_wr_c000;
  logic                     w_wr_c001;
  logic                     w_wr_e000;
  logic                     w_wr_e001;
  logic                     w_clk_evt;
  logic                     w_old_zero;
  logic                     w_take_latch;
  logic [COUNTER_WIDTH-1:0] w_evt_counter;
  logic                     w_en_eff;
  logic                     w_rev_ok;
  logic                     w_set_pend;
  logic                     w_unused;

  // Address bits 12..1 take no part in the decode (register mirrors).
  assign w_unused = &{1'b0, bus.cpu_addr_in[12:1]};

  // Old-revision chips only fire on a zero they arrived at by a decrement
  // or by an explicit reload; new-revision chips fire on any zero result.
  if (MMC3_REV_A) begin : g_rev_a
    assign w_rev_ok = ~w_old_zero | reload_q;
  end else begin : g_rev_new
    assign w_rev_ok = 1'b1;
  end

  // Write strobe and register decode from CPU A14..A13 and A0
  always_comb begin
    w_wr      = bus.mapper_active & ~bus.romsel & ~bus.cpu_rw_in;
    w_wr_c000 = w_wr & (bus.cpu_addr_in[14:13] == c_sel_c) & ~bus.cpu_addr_in[0];
    w_wr_c001 = w_wr & (bus.cpu_addr_in[14:13] == c_sel_c) &  bus.cpu_addr_in[0];
    w_wr_e000 = w_wr & (bus.cpu_addr_in[14:13] == c_sel_e) & ~bus.cpu_addr_in[0];
    w_wr_e001 = w_wr & (bus.cpu_addr_in[14:13] == c_sel_e) &  bus.cpu_addr_in[0];
  end

  // A12 low-time filter and qualified clock event
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (a12_s_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != c_low_min) begin
      low_cnt_d = low_cnt_q + LOW_W'(1);
    end
    // Uses the pre-clear count, so the rise itself still sees the full window.
    w_clk_evt = a12_s_q & ~prev_a12_q & (low_cnt_q == c_low_min);
  end

  // Counter, latch, enable and pending next-state with write priorities
  always_comb begin
    w_old_zero    = (counter_q == '0);
    w_take_latch  = w_old_zero | reload_q;
    w_evt_counter = w_take_latch ? latch_q : (counter_q - COUNTER_WIDTH'(1));
    // An $E001 write in the same cycle as a clock event already counts.
    w_en_eff      = irq_en_q | w_wr_e001;
    // A $C001 write swallows a coincident clock event.
    w_set_pend    = w_clk_evt & ~w_wr_c001 & (w_evt_counter == '0) &
                    w_en_eff & bus.mapper_active & w_rev_ok;

    counter_d = counter_q;
    latch_d   = latch_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;

    if (w_wr_c000) begin
      latch_d = COUNTER_WIDTH'(bus.cpu_data_in);
    end

    if (w_wr_c001) begin
      counter_d = '0;
      reload_d  = 1'b1;
    end else if (w_clk_evt) begin
      counter_d = w_evt_counter;
      reload_d  = 1'b0;
    end

    if (w_set_pend) begin
      pending_d = 1'b1;
    end

    // Acknowledge wins over a coincident pending-set.
    if (w_wr_e000) begin
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
    end else if (w_wr_e001) begin
      irq_en_d  = 1'b1;
    end
  end

  // A12 synchronizer, edge history and low counter
  always_ff @(posedge m2) begin
    if (reset) begin
      a12_meta_q <= 1'b0;
      a12_s_q    <= 1'b0;
      prev_a12_q <= 1'b0;
      low_cnt_q  <= '0;
    end else begin
      a12_meta_q <= bus.ppu_a12;
      a12_s_q    <= a12_meta_q;
      prev_a12_q <= a12_s_q;
      low_cnt_q  <= low_cnt_d;
    end
  end

  // Counter, latch and IRQ control registers
  always_ff @(posedge m2) begin
    if (reset) begin
      counter_q <= '0;
      latch_q   <= '0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      latch_q   <= latch_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
    end
  end

  // Registered active-low IRQ, gated by mapper selection
  always_ff @(posedge m2) begin
    if (reset) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= ~(pending_q & bus.mapper_active);
    end
  end

  assign bus.irq           = irq_q;
  assign bus.irq_pending   = pending_q;
  assign bus.counter_value = counter_q;

endmodule
`default_nettype wire

// File: tb/tb_mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmc3_scanline_irq
//  Purpose  : Self-checking bench for mmc3_scanline_irq: operation table,
//             hand-written corner sequences and randomized traffic, all
//             compared against a behavioural model every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmc3_scanline_irq;

  localparam int TB_LOW_MIN = 3;
  localparam bit TB_REV_A   = 1'b0;
  localparam int CW         = 8;
  localparam int MAXE       = 16384;

  logic m2 = 1'b0;
  logic reset;

  mmc3_scanline_irq_if #(.COUNTER_WIDTH(CW)) bus ();

  mmc3_scanline_irq #(
    .A12_LOW_MIN  (TB_LOW_MIN),
    .MMC3_REV_A   (TB_REV_A),
    .COUNTER_WIDTH(CW)
  ) dut (
    .m2   (m2),
    .reset(reset),
    .bus  (bus)
  );

  always #5 m2 = ~m2;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [CW-1:0] m_counter = '0;
  logic [CW-1:0] m_latch   = '0;
  bit            m_reload  = 1'b0;
  bit            m_en      = 1'b0;
  bit            m_pend    = 1'b0;
  bit            m_irq     = 1'b1;
  bit            raw_at [MAXE];
  int            t_edge    = 0;
  int            r_last    = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronized A12 as seen at edge x: the raw level two edges earlier,
  // or low while the reset-cleared synchronizer is still refilling.
  function automatic bit s_at(input int x);
    if (x - 2 > r_last && x - 2 >= 0) return raw_at[x-2];
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit ev, wr, c000, c001, e000, e001, en_now, old_zero, was_reload;
    raw_at[t_edge] = bus.ppu_a12;
    if (reset) begin
      m_counter = '0; m_latch = '0; m_reload = 0; m_en = 0; m_pend = 0; m_irq = 1;
      r_last = t_edge;
    end else begin
      // A rise counts when A12 is seen high after TB_LOW_MIN low samples since reset.
      ev = s_at(t_edge);
      for (int k = 1; k <= TB_LOW_MIN; k++)
        if (t_edge - k <= r_last || s_at(t_edge - k)) ev = 0;
      m_irq = !(m_pend && bus.mapper_active);
      wr   = bus.mapper_active && !bus.romsel && !bus.cpu_rw_in;
      c000 = wr && bus.cpu_addr_in[14:13] == 2'b10 && !bus.cpu_addr_in[0];
      c001 = wr && bus.cpu_addr_in[14:13] == 2'b10 &&  bus.cpu_addr_in[0];
      e000 = wr && bus.cpu_addr_in[14:13] == 2'b11 && !bus.cpu_addr_in[0];
      e001 = wr && bus.cpu_addr_in[14:13] == 2'b11 &&  bus.cpu_addr_in[0];
      en_now = m_en || e001;
      if (c001) begin
        m_counter = '0;
        m_reload  = 1;
      end else if (ev) begin
        old_zero   = (m_counter == 0);
        was_reload = m_reload;
        if (old_zero || m_reload) begin
          m_counter = m_latch;
          m_reload  = 0;
        end else begin
          m_counter = m_counter - 1'b1;
        end
        if (m_counter == 0 && en_now && bus.mapper_active &&
            (!TB_REV_A || !old_zero || was_reload))
          m_pend = 1;
      end
      if (c000) m_latch = bus.cpu_data_in;
      if (e000) begin m_en = 0; m_pend = 0; end
      if (e001) m_en = 1;
    end
    t_edge++;
  endtask

  task automatic step();
    @(posedge m2);
    model_edge();
    #1;
    check("cyc_counter", 32'(bus.counter_value), 32'(m_counter));
    check("cyc_pending", 32'(bus.irq_pending),   32'(m_pend));
    check("cyc_irq",     32'(bus.irq),           32'(m_irq));
  endtask

  task automatic cpu_write(input logic [14:0] addr, input logic [7:0] data);
    bus.romsel = 1'b0; bus.cpu_rw_in = 1'b0;
    bus.cpu_addr_in = addr; bus.cpu_data_in = data;
    step();
    bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
    step();
  endtask

  task automatic a12_rise(input int lows);
    bus.ppu_a12 = 1'b0;
    repeat (lows) step();
    bus.ppu_a12 = 1'b1;
    repeat (4) step();
  endtask

  typedef enum int {OP_RST, OP_WR, OP_RISE} op_e;
  typedef struct {
    op_e         op;
    logic [14:0] addr;
    logic [7:0]  data;
    int          lows;
    logic [7:0]  e_cnt;
    bit          e_pend;
    bit          e_irq;
    string       name;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(op_e op, logic [14:0] addr, logic [7:0] data, int lows,
                              logic [7:0] c, bit p, bit i, string name);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.lows = lows;
    v.e_cnt = c; v.e_pend = p; v.e_irq = i; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.mapper_active = 1'b1; bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
    bus.cpu_addr_in = '0; bus.cpu_data_in = '0; bus.ppu_a12 = 1'b0;

    // Basic countdown with latch 3
    add(OP_RST,  15'h0,    8'h0, 0, 8'd0, 0, 1, "reset");
    add(OP_WR,   15'h4000, 8'h3, 0, 8'd0, 0, 1, "wr_c000_3");
    add(OP_WR,   15'h4001, 8'h0, 0, 8'd0, 0, 1, "wr_c001");
    add(OP_WR,   15'h6001, 8'h0, 0, 8'd0, 0, 1, "wr_e001");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd3, 0, 1, "rise1_reload");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd2, 0, 1, "rise2_dec");
    add(OP_RISE, 15'h0,    8'h0, 4, 8'd1, 0, 1, "rise3_dec");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd0, 1, 0, "rise4_zero_irq");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd3, 1, 0, "rise5_reload_held");
    // Acknowledge and disabled countdown
    add(OP_WR,   15'h6000, 8'h0, 0, 8'd3, 0, 1, "wr_e000_ack");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd2, 0, 1, "dis_rise_a");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd1, 0, 1, "dis_rise_b");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd0, 0, 1, "dis_zero_no_irq");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd3, 0, 1, "dis_reload");
    add(OP_WR,   15'h6001, 8'h0, 0, 8'd3, 0, 1, "reenable");
    // Short low windows are filtered out
    add(OP_WR,   15'h4000, 8'h2, 0, 8'd3, 0, 1, "wr_latch_2");
    add(OP_WR,   15'h4001, 8'h0, 0, 8'd0, 0, 1, "wr_c001_b");
    add(OP_RISE, 15'h0,    8'h0, 2, 8'd0, 0, 1, "short_low_2");
    add(OP_RISE, 15'h0,    8'h0, 1, 8'd0, 0, 1, "short_low_1");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd2, 0, 1, "full_low_reload");
    // Latch 0 behaviour, revision dependent after the first reload
    add(OP_WR,   15'h4000, 8'h0, 0, 8'd2, 0, 1, "wr_latch_0");
    add(OP_WR,   15'h4001, 8'h0, 0, 8'd0, 0, 1, "wr_c001_c");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd0, 1, 0, "l0_first_rise");
    add(OP_WR,   15'h6000, 8'h0, 0, 8'd0, 0, 1, "l0_ack");
    add(OP_WR,   15'h6001, 8'h0, 0, 8'd0, 0, 1, "l0_enable");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd0, !TB_REV_A, TB_REV_A, "l0_second_rise");
    add(OP_RISE, 15'h0,    8'h0, 3, 8'd0, !TB_REV_A, TB_REV_A, "l0_third_rise");

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_RST:  begin reset = 1'b1; step(); reset = 1'b0; end
        OP_WR:   cpu_write(tbl[i].addr, tbl[i].data);
        default: a12_rise(tbl[i].lows);
      endcase
      check({tbl[i].name, "_cnt"},  32'(bus.counter_value), 32'(tbl[i].e_cnt));
      check({tbl[i].name, "_pend"}, 32'(bus.irq_pending),   32'(tbl[i].e_pend));
      check({tbl[i].name, "_irq"},  32'(bus.irq),           32'(tbl[i].e_irq));
    end

    // $C001 write on the very edge of a clock event, counter at 5
    cpu_write(15'h4000, 8'd5);
    cpu_write(15'h4001, 8'd0);
    a12_rise(3);
    check("c5_loaded", 32'(bus.counter_value), 32'd5);
    bus.ppu_a12 = 1'b0;
    repeat (3) step();
    bus.ppu_a12 = 1'b1;
    step();
    step();
    bus.romsel = 1'b0; bus.cpu_rw_in = 1'b0; bus.cpu_addr_in = 15'h4001;
    step();
    bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
    check("c001_beats_evt", 32'(bus.counter_value), 32'd0);
    repeat (2) step();
    a12_rise(3);
    check("reload_no_dec", 32'(bus.counter_value), 32'd5);

    // Mapper deselected: writes ignored, IRQ masked, counting continues
    cpu_write(15'h6000, 8'd0);
    cpu_write(15'h4000, 8'd1);
    cpu_write(15'h4001, 8'd0);
    cpu_write(15'h6001, 8'd0);
    a12_rise(3);
    check("ma_cnt_1", 32'(bus.counter_value), 32'd1);
    bus.mapper_active = 1'b0;
    cpu_write(15'h4000, 8'd7);
    cpu_write(15'h6000, 8'd0);
    a12_rise(3);
    check("ma0_cnt_0",  32'(bus.counter_value), 32'd0);
    check("ma0_pend_0", 32'(bus.irq_pending),   32'd0);
    check("ma0_irq_1",  32'(bus.irq),           32'd1);
    bus.mapper_active = 1'b1;
    a12_rise(3);
    check("ma1_latch_held", 32'(bus.counter_value), 32'd1);
    a12_rise(3);
    check("ma1_en_held", 32'(bus.irq_pending), 32'd1);

    // Reset mid-countdown, then a rise without a full low window
    cpu_write(15'h4000, 8'd3);
    cpu_write(15'h4001, 8'd0);
    a12_rise(3);
    a12_rise(3);
    check("pre_rst_cnt", 32'(bus.counter_value), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_cnt", 32'(bus.counter_value), 32'd0);
    check("rst_irq", 32'(bus.irq),           32'd1);
    cpu_write(15'h4000, 8'd4);
    repeat (3) step();
    check("no_window_after_rst", 32'(bus.counter_value), 32'd0);
    a12_rise(3);
    check("first_full_rise", 32'(bus.counter_value), 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 299) == 0);
      bus.mapper_active = ($urandom_range(0, 9) != 0);
      bus.romsel        = ($urandom_range(0, 3) != 0);
      bus.cpu_rw_in     = $urandom_range(0, 1) != 0;
      bus.cpu_addr_in   = 15'($urandom());
      if ($urandom_range(0, 3) != 0) bus.cpu_addr_in[14] = 1'b1;
      bus.cpu_data_in   = 8'($urandom_range(0, 5));
      if (bus.ppu_a12) bus.ppu_a12 = ($urandom_range(0, 3) != 0);
      else             bus.ppu_a12 = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
